// File: rtl/pet_cpu_clkctl_pkg.sv
// pet_pkg: shared definitions for the PET clocking blocks.
//   clkctl_state_t : CPU clock-enable controller states
//   PET_NOM_DIV    : master clocks per nominal 1 MHz CPU cycle
//   clamp_div()    : turbo divisor (base >> shift), floored at min_div
package pet_pkg;

    typedef enum logic [1:0] {RUN, HALT, STEP} clkctl_state_t;

    localparam int PET_NOM_DIV = 56;

    function automatic int clamp_div(input int base, input int shift, input int min_div);
        int d;
        d = base >> shift;
        return (d < min_div) ? min_div : d;
    endfunction

endpackage

// File: rtl/pet_cpu_clkctl_if.sv
// pet_cpu_clkctl_if: request/strobe bundle between the PET system top and
// the CPU clock-enable controller.
//   master : system side -> drives speed, turbo_req, stop_req, step (+cycle_clr)
//   slave  : controller  -> drives cpu_ce, phi2, ce_nom, stopped, cur_div (+cycle_cnt)
// Macro PET_CLKCTL_CYCLE_CNT_EN adds cycle_clr / cycle_cnt[31:0].
interface pet_cpu_clkctl_if #(
    parameter int SPEED_W = 2,
    parameter int DIV_W   = 6
);
    logic [SPEED_W-1:0] speed;
    logic               turbo_req;
    logic               stop_req;
    logic               step;
    logic               cpu_ce;
    logic               phi2;
    logic               ce_nom;
    logic               stopped;
    logic [DIV_W-1:0]   cur_div;
`ifdef PET_CLKCTL_CYCLE_CNT_EN
    logic               cycle_clr;
    logic [31:0]        cycle_cnt;

    modport master (output speed, turbo_req, stop_req, step, cycle_clr,
                    input  cpu_ce, phi2, ce_nom, stopped, cur_div, cycle_cnt);
    modport slave  (input  speed, turbo_req, stop_req, step, cycle_clr,
                    output cpu_ce, phi2, ce_nom, stopped, cur_div, cycle_cnt);
`else
    modport master (output speed, turbo_req, stop_req, step,
                    input  cpu_ce, phi2, ce_nom, stopped, cur_div);
    modport slave  (input  speed, turbo_req, stop_req, step,
                    output cpu_ce, phi2, ce_nom, stopped, cur_div);
`endif
endinterface

// File: rtl/pet_cpu_clkctl_clk_div.sv
// pet_clk_div: modulo-N counter. cnt runs 0..n_cur-1; on the terminal count
// (tc) it wraps to 0 and loads n_cur from n_next, so a modulus change never
// shortens the period in progress.
//   clk, rst_n : clock, async active-low reset
//   n_next     : modulus for the next period
//   cnt        : current count
//   n_cur      : modulus in effect (reset to N_RST)
//   tc         : high while cnt == n_cur-1
module pet_clk_div #(
    parameter int W     = 6,
    parameter int N_RST = 56
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] n_next,
    output logic [W-1:0] cnt,
    output logic [W-1:0] n_cur,
    output logic         tc
);
    assign tc = (cnt == n_cur - W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            n_cur <= W'(N_RST);
        end else if (tc) begin
            cnt   <= '0;
            n_cur <= n_next;
        end else begin
            cnt   <= cnt + W'(1);
        end
    end
endmodule

// File: rtl/pet_cpu_clkctl.sv
// pet_cpu_clkctl: CPU clock-enable controller for the PET system top.
// Programmable period (CLK_DIV >> speed, floored at MIN_DIV; turbo_req forces
// the fastest setting), stop/step handshake evaluated only on period
// boundaries, and a free-running nominal-rate strobe.
//   clk, reset_n : master clock, async active-low reset
//   bus (slave)  : speed, turbo_req, stop_req, step in;
//                  cpu_ce, phi2, ce_nom, stopped, cur_div out
// Macro PET_CLKCTL_CYCLE_CNT_EN adds a 32-bit cpu_ce counter with sync clear.
module pet_cpu_clkctl
    import pet_pkg::*;
#(
    parameter int CLK_DIV   = PET_NOM_DIV,
    parameter int SPEED_W   = 2,
    parameter int MIN_DIV   = 2,
    parameter int RESET_RUN = 1
) (
    input logic               clk,
    input logic               reset_n,
    pet_cpu_clkctl_if.slave   bus
);
    localparam int DW = $clog2(CLK_DIV + 1);

    logic [SPEED_W-1:0] sel;
    logic [DW-1:0]      eff, div_cnt, cur_div, nom_cnt, nom_div;
    logic               tc, nom_tc, unused_nom;
    clkctl_state_t      state, state_d;
    logic               step_q, step_pend, pend_d, step_rise;
    logic               cpu_ce_q, ce_d, phi2_q;

    assign sel = bus.turbo_req ? '1 : bus.speed;
    assign eff = DW'(clamp_div(CLK_DIV, int'(sel), MIN_DIV));

    pet_clk_div #(.W(DW), .N_RST(CLK_DIV)) u_cpu_div (
        .clk(clk), .rst_n(reset_n), .n_next(eff),
        .cnt(div_cnt), .n_cur(cur_div), .tc(tc)
    );

    pet_clk_div #(.W(DW), .N_RST(CLK_DIV)) u_nom_div (
        .clk(clk), .rst_n(reset_n), .n_next(DW'(CLK_DIV)),
        .cnt(nom_cnt), .n_cur(nom_div), .tc(nom_tc)
    );

    // The nominal counter only contributes its terminal count.
    assign unused_nom = ^{nom_cnt, nom_div};

    assign step_rise = bus.step & ~step_q;

    always_comb begin
        state_d = state;
        pend_d  = step_pend;
        ce_d    = 1'b0;
        // Step edges only count while halted; one pending step at most.
        if (state == HALT && step_rise) pend_d = 1'b1;
        if (tc) begin
            unique case (state)
                RUN: begin
                    if (bus.stop_req) state_d = HALT;
                    else              ce_d    = 1'b1;
                end
                HALT: begin
                    // Release beats a pending step; the step is dropped.
                    if (!bus.stop_req) begin
                        state_d = RUN;
                        pend_d  = 1'b0;
                    end else if (pend_d) begin
                        state_d = STEP;
                        pend_d  = 1'b0;
                    end
                end
                STEP: begin
                    ce_d    = 1'b1;
                    state_d = HALT;
                end
                default: state_d = HALT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= (RESET_RUN != 0) ? RUN : HALT;
            step_q    <= 1'b0;
            step_pend <= 1'b0;
            cpu_ce_q  <= 1'b0;
            phi2_q    <= 1'b0;
        end else begin
            state     <= state_d;
            step_q    <= bus.step;
            step_pend <= pend_d;
            cpu_ce_q  <= ce_d;
            phi2_q    <= (div_cnt >= (cur_div >> 1));
        end
    end

    assign bus.cpu_ce  = cpu_ce_q;
    assign bus.phi2    = phi2_q;
    assign bus.ce_nom  = nom_tc;
    assign bus.stopped = (state != RUN);
    assign bus.cur_div = cur_div;

`ifdef PET_CLKCTL_CYCLE_CNT_EN
    logic [31:0] cyc_cnt;

    // Clear wins over a coincident strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)           cyc_cnt <= '0;
        else if (bus.cycle_clr) cyc_cnt <= '0;
        else if (cpu_ce_q)      cyc_cnt <= cyc_cnt + 32'd1;
    end

    assign bus.cycle_cnt = cyc_cnt;
`endif
endmodule

// File: tb/tb_pet_cpu_clkctl.sv
module tb_pet_cpu_clkctl;
    import pet_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pet_cpu_clkctl_if #(.SPEED_W(2), .DIV_W(6)) bus ();
    pet_cpu_clkctl_if #(.SPEED_W(2), .DIV_W(6)) bus_h ();

    pet_cpu_clkctl #(.CLK_DIV(56), .SPEED_W(2), .MIN_DIV(2), .RESET_RUN(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    pet_cpu_clkctl #(.CLK_DIV(56), .SPEED_W(2), .MIN_DIV(2), .RESET_RUN(0)) u_halt (
        .clk(clk), .reset_n(reset_n), .bus(bus_h)
    );

    // Negedges until the next cpu_ce (bounded); ok=0 on timeout.
    task automatic wait_ce(output int n, output bit ok);
        n = 0; ok = 1'b0;
        while (!ok && n < 400) begin
            @(negedge clk); n++; ok = bus.cpu_ce;
        end
    endtask

    task automatic wait_nom(output int n, output bit ok);
        n = 0; ok = 1'b0;
        while (!ok && n < 400) begin
            @(negedge clk); n++; ok = bus.ce_nom;
        end
    endtask

    task automatic test_reset;
        bus.speed = '0; bus.turbo_req = 0; bus.stop_req = 0; bus.step = 0;
        bus_h.speed = '0; bus_h.turbo_req = 0; bus_h.stop_req = 0; bus_h.step = 0;
`ifdef PET_CLKCTL_CYCLE_CNT_EN
        bus.cycle_clr = 0; bus_h.cycle_clr = 0;
`endif
        reset_n = 0;
        repeat (3) @(negedge clk);
        checks++; if (bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL rst_cpu_ce: got %0b exp 0", bus.cpu_ce); end
        checks++; if (bus.ce_nom !== 1'b0) begin errors++; $display("FAIL rst_ce_nom: got %0b exp 0", bus.ce_nom); end
        checks++; if (bus.phi2 !== 1'b0) begin errors++; $display("FAIL rst_phi2: got %0b exp 0", bus.phi2); end
        checks++; if (bus.stopped !== 1'b0) begin errors++; $display("FAIL rst_stopped: got %0b exp 0", bus.stopped); end
        checks++; if (bus.cur_div !== 6'd56) begin errors++; $display("FAIL rst_cur_div: got %0d exp 56", bus.cur_div); end
        checks++; if (bus_h.stopped !== 1'b1) begin errors++; $display("FAIL rst_halt_stopped: got %0b exp 1", bus_h.stopped); end
        reset_n = 1;
    endtask

    task automatic test_default;
        int n; bit ok; int phi_cnt; int ce_cnt; int nom_cnt;
        wait_ce(n, ok);
        checks++; if (!ok || n != 56) begin errors++; $display("FAIL first_ce: got %0d clks exp 56", n); end
        wait_ce(n, ok);
        checks++; if (!ok || n != 56) begin errors++; $display("FAIL ce_period56: got %0d exp 56", n); end
        phi_cnt = 0; ce_cnt = 0; nom_cnt = 0;
        for (int i = 0; i < 56; i++) begin
            @(negedge clk);
            phi_cnt += int'(bus.phi2); ce_cnt += int'(bus.cpu_ce); nom_cnt += int'(bus.ce_nom);
        end
        checks++; if (phi_cnt != 28) begin errors++; $display("FAIL phi2_duty: got %0d exp 28", phi_cnt); end
        checks++; if (ce_cnt != 1) begin errors++; $display("FAIL ce_per_period: got %0d exp 1", ce_cnt); end
        checks++; if (nom_cnt != 1) begin errors++; $display("FAIL nom_per_period: got %0d exp 1", nom_cnt); end
        checks++; if (bus.stopped !== 1'b0) begin errors++; $display("FAIL run_stopped: got %0b exp 0", bus.stopped); end
    endtask

    task automatic test_speed;
        int n; bit ok;
        wait_ce(n, ok);
        repeat (10) @(negedge clk);
        bus.speed = 2'd2;
        wait_ce(n, ok);
        checks++; if (!ok || n != 46) begin errors++; $display("FAIL speed_finish_period: got %0d exp 46", n); end
        wait_ce(n, ok);
        checks++; if (!ok || n != 14) begin errors++; $display("FAIL speed2_period: got %0d exp 14", n); end
        checks++; if (bus.cur_div !== 6'd14) begin errors++; $display("FAIL speed2_cur_div: got %0d exp 14", bus.cur_div); end
        wait_nom(n, ok);
        wait_nom(n, ok);
        checks++; if (!ok || n != 56) begin errors++; $display("FAIL nom_at_speed2: got %0d exp 56", n); end
    endtask

    task automatic test_turbo;
        int n; bit ok;
        wait_ce(n, ok);
        repeat (3) @(negedge clk);
        bus.speed = 2'd0; bus.turbo_req = 1;
        wait_ce(n, ok);
        checks++; if (!ok || n != 11) begin errors++; $display("FAIL turbo_finish_period: got %0d exp 11", n); end
        wait_ce(n, ok);
        checks++; if (!ok || n != 7) begin errors++; $display("FAIL turbo_period: got %0d exp 7", n); end
        checks++; if (bus.cur_div !== 6'd7) begin errors++; $display("FAIL turbo_cur_div: got %0d exp 7", bus.cur_div); end
        repeat (2) @(negedge clk);
        bus.turbo_req = 0;
        wait_ce(n, ok);
        checks++; if (!ok || n != 5) begin errors++; $display("FAIL unturbo_finish: got %0d exp 5", n); end
        wait_ce(n, ok);
        checks++; if (!ok || n != 56) begin errors++; $display("FAIL unturbo_period: got %0d exp 56", n); end
        checks++; if (bus.cur_div !== 6'd56) begin errors++; $display("FAIL unturbo_cur_div: got %0d exp 56", bus.cur_div); end
    endtask

    task automatic test_stop;
        int n; bit ok; int ce_cnt; int nom_cnt; int run_cnt;
        wait_ce(n, ok);
        repeat (45) @(negedge clk);
        bus.stop_req = 1;
        repeat (10) @(negedge clk);
        checks++; if (bus.stopped !== 1'b0) begin errors++; $display("FAIL stop_early: got %0b exp 0", bus.stopped); end
        @(negedge clk);
        checks++; if (bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL stop_suppress: got %0b exp 0", bus.cpu_ce); end
        checks++; if (bus.stopped !== 1'b1) begin errors++; $display("FAIL stop_ack: got %0b exp 1", bus.stopped); end
        ce_cnt = 0; nom_cnt = 0; run_cnt = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            ce_cnt += int'(bus.cpu_ce); nom_cnt += int'(bus.ce_nom); run_cnt += int'(!bus.stopped);
        end
        checks++; if (ce_cnt != 0) begin errors++; $display("FAIL halted_ce: got %0d exp 0", ce_cnt); end
        checks++; if (nom_cnt < 8) begin errors++; $display("FAIL halted_nom: got %0d exp >=8", nom_cnt); end
        checks++; if (run_cnt != 0) begin errors++; $display("FAIL halted_stopped: got %0d low clks exp 0", run_cnt); end
    endtask

    task automatic test_step;
        int ce_cnt; int off_cnt; int run_cnt;
        ce_cnt = 0; off_cnt = 0; run_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            bus.step = 1;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                bus.step = 0;
                if (bus.cpu_ce) begin
                    ce_cnt++;
                    if (u_dut.div_cnt != 6'd0) off_cnt++;
                end
                run_cnt += int'(!bus.stopped);
            end
        end
        checks++; if (ce_cnt != 3) begin errors++; $display("FAIL step_count: got %0d exp 3", ce_cnt); end
        checks++; if (off_cnt != 0) begin errors++; $display("FAIL step_boundary: got %0d off-boundary exp 0", off_cnt); end
        checks++; if (run_cnt != 0) begin errors++; $display("FAIL step_stopped: got %0d low clks exp 0", run_cnt); end
    endtask

    task automatic test_step_resume;
        int n; bit ok; int ce_cnt;
        bus.step = 1;
        @(negedge clk);
        bus.step = 0;
        wait_ce(n, ok);
        checks++; if (!ok) begin errors++; $display("FAIL resume_setup_step: got timeout exp cpu_ce"); end
        repeat (55) @(negedge clk);
        bus.step = 1; bus.stop_req = 0;
        @(negedge clk);
        bus.step = 0;
        checks++; if (bus.stopped !== 1'b0) begin errors++; $display("FAIL resume_run_wins: got %0b exp 0", bus.stopped); end
        ce_cnt = 0;
        for (int i = 57; i < 112; i++) begin
            @(negedge clk); ce_cnt += int'(bus.cpu_ce);
        end
        checks++; if (ce_cnt != 0) begin errors++; $display("FAIL resume_no_early_ce: got %0d exp 0", ce_cnt); end
        @(negedge clk);
        checks++; if (bus.cpu_ce !== 1'b1) begin errors++; $display("FAIL resume_first_ce: got %0b exp 1", bus.cpu_ce); end
        wait_ce(n, ok);
        checks++; if (!ok || n != 56) begin errors++; $display("FAIL resume_second_ce: got %0d exp 56", n); end
    endtask

    task automatic test_reset_mid_step;
        int n;
        bus.stop_req = 1;
        n = 0;
        while (!bus.stopped && n < 200) begin @(negedge clk); n++; end
        bus.step = 1;
        @(negedge clk);
        bus.step = 0;
        n = 0;
        while (u_dut.state != STEP && n < 200) begin @(negedge clk); n++; end
        checks++; if (u_dut.state != STEP) begin errors++; $display("FAIL reach_step: got %0d exp %0d", u_dut.state, STEP); end
        @(posedge clk);
        #2 reset_n = 0;
        #1;
        checks++; if (bus.stopped !== 1'b0) begin errors++; $display("FAIL mid_rst_stopped: got %0b exp 0", bus.stopped); end
        checks++; if (bus.cpu_ce !== 1'b0 || bus.phi2 !== 1'b0 || bus.ce_nom !== 1'b0) begin
            errors++; $display("FAIL mid_rst_strobes: got ce=%0b phi2=%0b nom=%0b exp 0", bus.cpu_ce, bus.phi2, bus.ce_nom);
        end
        checks++; if (bus.cur_div !== 6'd56) begin errors++; $display("FAIL mid_rst_cur_div: got %0d exp 56", bus.cur_div); end
        checks++; if (bus_h.stopped !== 1'b1) begin errors++; $display("FAIL mid_rst_halt_stopped: got %0b exp 1", bus_h.stopped); end
`ifdef PET_CLKCTL_CYCLE_CNT_EN
        checks++; if (bus.cycle_cnt !== 32'd0) begin errors++; $display("FAIL mid_rst_cycle_cnt: got %0d exp 0", bus.cycle_cnt); end
`endif
        @(negedge clk);
        bus.stop_req = 0;
        reset_n = 1;
    endtask

    task automatic test_cycle_cnt;
`ifdef PET_CLKCTL_CYCLE_CNT_EN
        int n; bit ok;
        repeat (170) @(negedge clk);
        checks++; if (bus.cycle_cnt !== 32'd3) begin errors++; $display("FAIL cycle_cnt3: got %0d exp 3", bus.cycle_cnt); end
        bus.cycle_clr = 1;
        @(negedge clk);
        bus.cycle_clr = 0;
        checks++; if (bus.cycle_cnt !== 32'd0) begin errors++; $display("FAIL cycle_clr: got %0d exp 0", bus.cycle_cnt); end
        wait_ce(n, ok);
        bus.cycle_clr = 1;
        @(negedge clk);
        bus.cycle_clr = 0;
        checks++; if (!ok || bus.cycle_cnt !== 32'd0) begin errors++; $display("FAIL cycle_clr_vs_ce: got %0d exp 0", bus.cycle_cnt); end
`endif
    endtask

    initial begin
        test_reset;
        test_default;
        test_speed;
        test_turbo;
        test_stop;
        test_step;
        test_step_resume;
        test_reset_mid_step;
        test_cycle_cnt;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pet_cpu_clkctl.md
Name: pet_cpu_clkctl

Overview:
- Parametrised CPU clock-enable controller for the PET system top.
- Replaces fixed ce_1m / clk_speed / clk_stop handling with a programmable divider, 2^n turbo modes, a stop/step handshake and a free-running nominal-rate strobe for video, audio and timers.
- Sits between the master clock and the cpu6502 + pet2001hw pair; its cpu_ce drives their cycle enable.

Parameters:
- CLK_DIV, 56: master clk cycles per nominal 1 MHz CPU cycle; must be ≥ 4.
- SPEED_W, 2: width of speed select; speed s gives divisor CLK_DIV >> s.
- MIN_DIV, 2: floor on the turbo divisor.
- RESET_RUN, 1: state after reset; 1 = RUN, 0 = HALT.

Ports:
- clk  in  1  master clock
- reset_n  in  1  asynchronous, active-low reset
- speed  in  SPEED_W  turbo select; 0 = nominal
- turbo_req  in  1  forces maximum speed (all-ones) while high, e.g. during tape load
- stop_req  in  1  level; request CPU halt
- step  in  1  pulse; execute one CPU cycle while halted
- cpu_ce  out  1  one-clk strobe per CPU cycle
- phi2  out  1  high during the second half of the current CPU period
- ce_nom  out  1  one-clk strobe every CLK_DIV clks, independent of speed and stop
- stopped  out  1  CPU halted (stop acknowledge)
- cur_div  out  $clog2(CLK_DIV+1)  divisor currently in effect

Behaviour:
- Reset (async, reset_n = 0):
  - div_cnt = 0, nom_cnt = 0.
  - cpu_ce = 0, ce_nom = 0, phi2 = 0.
  - cur_div = CLK_DIV.
  - State = RUN if RESET_RUN else HALT; stopped = !RESET_RUN.
- Effective divisor: eff = max(CLK_DIV >> (turbo_req ? all-ones : speed), MIN_DIV).
- Period counter:
  - div_cnt counts 0..cur_div-1 and wraps to 0. The wrap is the "boundary".
  - At each boundary cur_div <= eff, so speed/turbo changes take effect only on a period boundary. No short or runt periods.
- phi2 = (div_cnt >= cur_div/2), registered.
- Nominal counter:
  - nom_cnt counts 0..CLK_DIV-1; ce_nom = 1 for the clk where nom_cnt = CLK_DIV-1.
  - Never gated by state or speed.
- State machine, with evaluation at boundaries only:
  - RUN
    - stop_req = 1 → HALT: no cpu_ce this boundary; stopped = 1 from the next clk.
    - otherwise cpu_ce = 1 for one clk.
  - HALT
    - A step rising edge (edge-detected, any time) latches step_pend.
    - At a boundary, stop_req = 0 → RUN: stopped = 0; the first cpu_ce comes at the following boundary.
    - Otherwise, if step_pend → STEP; step_pend is cleared.
  - STEP
    - At the next boundary: cpu_ce = 1 exactly once, return to HALT. stopped stays 1.
- Simultaneous events:
  - stop_req deassert and a pending step at the same HALT boundary: RUN wins and step_pend is cleared.
  - Steps while RUN or STEP are ignored; no queueing beyond one pending step.
- Latency:
  - stop_req assertion to stopped: ≤ cur_div + 1 clks.
  - At most one cpu_ce after stop_req is sampled high: none, since the boundary itself is suppressed.
- cpu_ce is never asserted in two consecutive clks (MIN_DIV ≥ 2).
- Reset mid-operation clears all state; no partial period survives.

Optional Feature:
- Macro: PET_CLKCTL_CYCLE_CNT_EN.
- Defined:
  - Adds output cycle_cnt [31:0], counting cpu_ce strobes; wraps at 2^32; reset to 0.
  - Adds input cycle_clr, a synchronous clear. When cycle_clr and cpu_ce occur in the same clk, the result is 0.
- Undefined: neither port exists and no counter logic is generated.

Decomposition:
- Shared package pet_pkg:
  - typedef clkctl_state_t {RUN, HALT, STEP}.
  - Constant PET_NOM_DIV = 56.
  - Function for computing the clamped divisor (shared with a future video timing block).
- One natural sub-module: pet_clk_div.
  - Generic modulo-N counter with load-at-wrap and a terminal-count strobe.
  - Instantiated twice: the CPU period counter and the nominal counter.

Test Plan:
- Reset release, speed = 0, defaults: cpu_ce every 56 clks, ce_nom every 56 clks, stopped = 0, cur_div = 56.
- speed 0→2 mid-period: current 56-clk period completes, then cpu_ce every 14 clks; ce_nom stays at 56.
- turbo_req = 1 with speed = 0: divisor max(56>>3, 2) = 7 from the next boundary. Deassert → back to 56 at the following boundary.
- stop_req asserted 10 clks before a boundary: no cpu_ce at that boundary, stopped = 1 one clk later. Zero cpu_ce over the next 500 clks; ce_nom continues.
- While halted:
  - Three step pulses spaced 200 clks apart → exactly 3 cpu_ce, each on a boundary, stopped held at 1.
  - Step and stop_req deassert landing on the same boundary → RUN, one step lost.
- reset_n pulsed low mid-STEP: outputs zero asynchronously. With RESET_RUN = 0, stopped = 1 after reset; with the cycle-count macro defined, cycle_cnt = 0.
